// File: rtl/apb_clkctrl_pkg.sv
// Shared types and status-register offsets for the APB clock-generator bridge.
package apb_clkctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_REL,
        ST_RESP
    } state_t;

    // Status words sit directly after the channel windows, at 4*NUM_CH + offset.
    localparam int unsigned REG_LOCK     = 0;
    localparam int unsigned REG_LOCKLOST = 1;
    localparam int unsigned REG_TOERR    = 2;

endpackage

// File: rtl/apb_clkctrl_if_sync.sv
// Generic single-bit synchroniser, synchronous active-high reset.
module clkctrl_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic HCLK,
    input  logic HRESET,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge HCLK) begin
        if (HRESET) chain <= '0;
        else        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/apb_clkctrl_if.sv
// APB slave bridging to NUM_CH clock-generator config ports over a 4-phase
// req/ack handshake, with per-phase timeout and sticky lock-loss/timeout status.
module apb_clkctrl_if
    import apb_clkctrl_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]              PWDATA,
    input  logic                     PWRITE,
    input  logic                     PSEL,
    input  logic                     PENABLE,
    output logic [31:0]              PRDATA,
    output logic                     PREADY,
    output logic                     PSLVERR,
    output logic [NUM_CH-1:0]        ch_req_o,
    output logic                     ch_wrn_o,
    output logic [1:0]               ch_add_o,
    output logic [31:0]              ch_data_o,
    input  logic [NUM_CH-1:0]        ch_ack_i,
    input  logic [32*NUM_CH-1:0]     ch_r_data_i,
    input  logic [NUM_CH-1:0]        ch_lock_i
);

    localparam int unsigned WW  = APB_ADDR_WIDTH - 2;
    localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [WW-1:0] W_CH_END   = WW'(4 * NUM_CH);
    localparam logic [WW-1:0] W_LOCK     = WW'(4 * NUM_CH + REG_LOCK);
    localparam logic [WW-1:0] W_LOCKLOST = WW'(4 * NUM_CH + REG_LOCKLOST);
    localparam logic [WW-1:0] W_TOERR    = WW'(4 * NUM_CH + REG_TOERR);

    state_t state, state_nxt;

    logic [WW-1:0]     word;
    logic [CHW-1:0]    word_ch;
    logic              apb_act, is_ch, st_wr;
    logic [NUM_CH-1:0] ack_sync, lock_sync, lock_prev;
    logic [NUM_CH-1:0] toerr_q, locklost_q, set_toerr, clr_toerr, clr_locklost;
    logic [CHW-1:0]    ch_q;
    logic [1:0]        add_q;
    logic [31:0]       data_q, rdata_q;
    logic              wrn_q, err_q;
    logic [CW-1:0]     cnt_q;
    logic              latch, capture, to_fire, cnt_load;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_sync
        clkctrl_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
            .HCLK(HCLK), .HRESET(HRESET), .d(ch_ack_i[c]), .q(ack_sync[c])
        );
        clkctrl_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
            .HCLK(HCLK), .HRESET(HRESET), .d(ch_lock_i[c]), .q(lock_sync[c])
        );
    end

    assign word    = PADDR[APB_ADDR_WIDTH-1:2];
    assign word_ch = CHW'(word >> 2);
    assign apb_act = PSEL & PENABLE;
    assign is_ch   = (word < W_CH_END);
    assign st_wr   = apb_act & PWRITE & ~is_ch & (state == ST_IDLE);

    assign clr_locklost = (st_wr && word == W_LOCKLOST) ? PWDATA[NUM_CH-1:0] : '0;
    assign clr_toerr    = (st_wr && word == W_TOERR)    ? PWDATA[NUM_CH-1:0] : '0;
    assign set_toerr    = to_fire ? (NUM_CH'(1) << ch_q) : '0;

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        capture   = 1'b0;
        to_fire   = 1'b0;
        cnt_load  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (apb_act && is_ch) begin
                    latch = 1'b1;
                    // A channel with a pending timeout is refused without a request.
                    if (toerr_q[word_ch]) begin
                        state_nxt = ST_RESP;
                    end else begin
                        state_nxt = ST_REQ;
                        cnt_load  = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (cnt_q == '0) begin
                    to_fire   = 1'b1;
                    state_nxt = ST_RESP;
                end else if (ack_sync[ch_q]) begin
                    capture   = 1'b1;
                    cnt_load  = 1'b1;
                    state_nxt = ST_REL;
                end
            end
            ST_REL: begin
                if (cnt_q == '0) begin
                    to_fire   = 1'b1;
                    state_nxt = ST_RESP;
                end else if (!ack_sync[ch_q]) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= ST_IDLE;
            ch_q       <= '0;
            add_q      <= '0;
            data_q     <= '0;
            wrn_q      <= 1'b1;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            toerr_q    <= '0;
            locklost_q <= '0;
            lock_prev  <= '0;
        end else begin
            state     <= state_nxt;
            lock_prev <= lock_sync;
            if (latch) begin
                ch_q    <= word_ch;
                add_q   <= word[1:0];
                data_q  <= PWDATA;
                wrn_q   <= ~PWRITE;
                rdata_q <= '0;
                err_q   <= toerr_q[word_ch];
            end
            if (capture && wrn_q) rdata_q <= ch_r_data_i[32*int'(ch_q) +: 32];
            if (to_fire) err_q <= 1'b1;
            if (state == ST_RESP) begin
                wrn_q  <= 1'b1;
                add_q  <= '0;
                data_q <= '0;
            end
            if (cnt_load)
                cnt_q <= CW'(TIMEOUT_CYCLES);
            else if ((state == ST_REQ || state == ST_REL) && cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
            // Set beats a same-cycle W1C clear on both sticky registers.
            toerr_q    <= (toerr_q & ~clr_toerr) | set_toerr;
            locklost_q <= (locklost_q & ~clr_locklost) | (lock_prev & ~lock_sync);
        end
    end

    assign ch_req_o  = (state == ST_REQ && cnt_q != '0) ? (NUM_CH'(1) << ch_q) : '0;
    assign ch_wrn_o  = wrn_q;
    assign ch_add_o  = add_q;
    assign ch_data_o = data_q;

    assign PREADY  = apb_act & ((state == ST_RESP) | ((state == ST_IDLE) & ~is_ch));
    assign PSLVERR = apb_act & (state == ST_RESP) & err_q;

    always_comb begin
        PRDATA = '0;
        if (apb_act) begin
            if (state == ST_RESP) begin
                if (!err_q && wrn_q) PRDATA = rdata_q;
            end else if (state == ST_IDLE && !is_ch) begin
                case (word)
                    W_LOCK:     PRDATA = 32'(lock_sync);
                    W_LOCKLOST: PRDATA = 32'(locklost_q);
                    W_TOERR:    PRDATA = 32'(toerr_q);
                    default:    PRDATA = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apb_clkctrl_if.sv
// Directed bench for apb_clkctrl_if: vector table plus timeout, lock-loss and reset sequences.
module tb_apb_clkctrl_if;

    logic         HCLK, HRESET;
    logic [11:0]  PADDR;
    logic [31:0]  PWDATA, PRDATA;
    logic         PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
    logic [3:0]   ch_req_o, ch_ack_i, ch_lock_i, ack_en;
    logic         ch_wrn_o;
    logic [1:0]   ch_add_o;
    logic [31:0]  ch_data_o;
    logic [127:0] ch_r_data_i;

    int n_tests = 0;
    int n_fail  = 0;

    apb_clkctrl_if #(
        .APB_ADDR_WIDTH(12), .NUM_CH(4), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .ch_req_o(ch_req_o),
        .ch_wrn_o(ch_wrn_o), .ch_add_o(ch_add_o), .ch_data_o(ch_data_o),
        .ch_ack_i(ch_ack_i), .ch_r_data_i(ch_r_data_i), .ch_lock_i(ch_lock_i)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Clock-generator model: ack follows req three cycles later.
    logic [2:0] dly [4];
    always @(posedge HCLK) begin
        for (int c = 0; c < 4; c++)
            dly[c] <= HRESET ? 3'b000 : {dly[c][1:0], ch_req_o[c]};
    end
    always_comb begin
        ch_ack_i = '0;
        for (int c = 0; c < 4; c++) ch_ack_i[c] = ack_en[c] & dly[c][2];
    end

    // Bus monitor: request edges, request-high cycles, shared-bus stability.
    int         rise_cnt [4] = '{0, 0, 0, 0};
    int         req_hi = 0;
    int         stable_err = 0;
    int         onehot_err = 0;
    logic [3:0] prev_req = '0;
    logic [34:0] prev_bus = '0;
    logic [1:0] mon_add = '0;
    logic [31:0] mon_data = '0;
    logic       mon_wrn = 1'b0;
    always @(negedge HCLK) begin
        for (int c = 0; c < 4; c++)
            if (ch_req_o[c] && !prev_req[c]) rise_cnt[c] <= rise_cnt[c] + 1;
        if ((ch_req_o & ~prev_req) != 4'b0000) begin
            mon_add  <= ch_add_o;
            mon_data <= ch_data_o;
            mon_wrn  <= ch_wrn_o;
        end
        if (ch_req_o != 4'b0000) req_hi <= req_hi + 1;
        if (ch_req_o != 4'b0000 && ch_req_o == prev_req && {ch_wrn_o, ch_add_o, ch_data_o} != prev_bus)
            stable_err <= stable_err + 1;
        if ($countones(ch_req_o) > 1) onehot_err <= onehot_err + 1;
        prev_req <= ch_req_o;
        prev_bus <= {ch_wrn_o, ch_add_o, ch_data_o};
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int waits);
        @(posedge HCLK) #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
        @(posedge HCLK) #1;
        PENABLE = 1'b1;
        waits = 0;
        rd = '0; er = 1'b0;
        forever begin
            @(negedge HCLK);
            if (PREADY) begin
                rd = PRDATA; er = PSLVERR;
                break;
            end
            waits++;
            if (waits > 300) begin
                n_tests++; n_fail++;
                $display("FAIL apb_timeout: no PREADY at addr %h", addr);
                break;
            end
        end
        @(posedge HCLK) #1;
        PSEL = 1'b0; PENABLE = 1'b0; PADDR = 12'hFFC; PWDATA = 32'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    typedef struct {
        string       name;
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [3:0]  exp_req;
        int          exp_waits;
    } vec_t;

    vec_t vecs [10];

    logic [31:0] rd;
    logic        er;
    int          waits;
    int          r0 [4];
    int          hi0, st0, oh0;
    logic [3:0]  got_mask;
    int          got_rises;

    task automatic snap();
        for (int c = 0; c < 4; c++) r0[c] = rise_cnt[c];
        hi0 = req_hi; st0 = stable_err; oh0 = onehot_err;
    endtask

    task automatic rises();
        got_rises = 0; got_mask = '0;
        for (int c = 0; c < 4; c++) begin
            got_rises += rise_cnt[c] - r0[c];
            got_mask[c] = (rise_cnt[c] != r0[c]);
        end
    endtask

    initial begin
        vecs[0] = '{"wr_ch2_r1",   1'b1, 12'h024, 32'hA5A5_0001, 32'h0,          1'b0, 4'b0100, -1};
        vecs[1] = '{"rd_ch0_r3",   1'b0, 12'h00C, 32'h0,         32'hDEAD_BEEF, 1'b0, 4'b0001, -1};
        vecs[2] = '{"rd_ch3_r0",   1'b0, 12'h030, 32'h0,         32'h3333_0000, 1'b0, 4'b1000, -1};
        vecs[3] = '{"wr_ch1_r2",   1'b1, 12'h018, 32'h5A5A_1234, 32'h0,          1'b0, 4'b0010, -1};
        vecs[4] = '{"rd_lock",     1'b0, 12'h040, 32'h0,         32'h0000_0009, 1'b0, 4'b0000, 0};
        vecs[5] = '{"rd_unmapped", 1'b0, 12'h054, 32'h0,         32'h0,          1'b0, 4'b0000, 0};
        vecs[6] = '{"rd_ch1_r1",   1'b0, 12'h014, 32'h0,         32'h1111_2222, 1'b0, 4'b0010, -1};
        vecs[7] = '{"wr_unmapped", 1'b1, 12'h054, 32'hFFFF_FFFF, 32'h0,          1'b0, 4'b0000, 0};
        vecs[8] = '{"rd_toerr",    1'b0, 12'h048, 32'h0,         32'h0,          1'b0, 4'b0000, 0};
        vecs[9] = '{"rd_ch2_r0",   1'b0, 12'h020, 32'h0,         32'h2222_0000, 1'b0, 4'b0100, -1};

        HRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; ack_en = 4'b1111; ch_lock_i = 4'b1001;
        ch_r_data_i = {32'h3333_0000, 32'h2222_0000, 32'h1111_2222, 32'hDEAD_BEEF};
        repeat (4) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_req",    32'(ch_req_o),  32'h0);
        check("rst_wrn",    32'(ch_wrn_o),  32'h1);
        check("rst_add",    32'(ch_add_o),  32'h0);
        check("rst_data",   ch_data_o,      32'h0);
        check("rst_ready",  32'(PREADY),    32'h0);
        check("rst_slverr", 32'(PSLVERR),   32'h0);
        check("rst_prdata", PRDATA,         32'h0);
        @(posedge HCLK) #1;
        HRESET = 1'b0;
        idle(4);

        for (int i = 0; i < 10; i++) begin
            snap();
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, waits);
            idle(6);
            rises();
            check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            check({vecs[i].name, "_err"}, 32'(er), 32'(vecs[i].exp_err));
            check({vecs[i].name, "_reqmask"}, 32'(got_mask), 32'(vecs[i].exp_req));
            check({vecs[i].name, "_nreq"}, got_rises, $countones(vecs[i].exp_req));
            if (vecs[i].exp_waits >= 0)
                check({vecs[i].name, "_waits"}, waits, vecs[i].exp_waits);
            if (vecs[i].exp_req != 4'b0000) begin
                check({vecs[i].name, "_add"}, 32'(mon_add), 32'(vecs[i].addr[3:2]));
                check({vecs[i].name, "_data"}, mon_data, vecs[i].wdata);
                check({vecs[i].name, "_wrn"}, 32'(mon_wrn), 32'(!vecs[i].wr));
                check({vecs[i].name, "_stable"}, stable_err - st0, 0);
            end
            check({vecs[i].name, "_onehot"}, onehot_err - oh0, 0);
        end

        // Timeout on channel 1, sticky TOERR, fast refusal, W1C recovery.
        ack_en = 4'b1101;
        snap();
        apb(1'b0, 12'h010, 32'h0, rd, er, waits);
        idle(4);
        rises();
        check("to_err",    32'(er), 32'h1);
        check("to_rdata",  rd, 32'h0);
        check("to_reqcyc", req_hi - hi0, 16);
        check("to_nreq",   got_rises, 1);
        apb(1'b0, 12'h048, 32'h0, rd, er, waits);
        check("toerr_rd",  rd, 32'h2);
        snap();
        apb(1'b1, 12'h010, 32'h1234_5678, rd, er, waits);
        idle(4);
        rises();
        check("toerr_fast_err",  32'(er), 32'h1);
        check("toerr_fast_nreq", got_rises, 0);
        check("toerr_fast_waits", waits, 1);
        apb(1'b1, 12'h048, 32'h2, rd, er, waits);
        apb(1'b0, 12'h048, 32'h0, rd, er, waits);
        check("toerr_clr_rd", rd, 32'h0);
        ack_en = 4'b1111;
        apb(1'b0, 12'h014, 32'h0, rd, er, waits);
        check("ch1_recov_err",   32'(er), 32'h0);
        check("ch1_recov_rdata", rd, 32'h1111_2222);

        // Lock loss on ch3 appears SYNC_STAGES+1 edges after the fall.
        @(posedge HCLK) #1;
        ch_lock_i[3] = 1'b0;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 12'h044;
        for (int k = 0; k < 4; k++) begin
            @(negedge HCLK);
            if (k == 2) check("ll_early", PRDATA, 32'h0);
            if (k == 3) check("ll_set",   PRDATA, 32'h8);
        end
        @(posedge HCLK) #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        ch_lock_i[3] = 1'b1;
        idle(5);
        apb(1'b1, 12'h044, 32'h8, rd, er, waits);
        apb(1'b0, 12'h044, 32'h0, rd, er, waits);
        check("ll_w1c", rd, 32'h0);
        // New fall lands on the same edge as a W1C of bit 3.
        @(posedge HCLK) #1;
        ch_lock_i[3] = 1'b0;
        @(posedge HCLK) #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h044; PWDATA = 32'h8;
        @(posedge HCLK) #1;
        PENABLE = 1'b1;
        @(negedge HCLK);
        check("ll_w1c_ready", 32'(PREADY), 32'h1);
        @(posedge HCLK) #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        apb(1'b0, 12'h044, 32'h0, rd, er, waits);
        check("ll_set_wins", rd, 32'h8);

        // Reset while a request is outstanding.
        @(posedge HCLK) #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h008; PWDATA = 32'hCAFE_0000;
        @(posedge HCLK) #1;
        PENABLE = 1'b1;
        @(posedge HCLK) #1;
        @(negedge HCLK);
        check("mid_req", 32'(ch_req_o), 32'h1);
        @(posedge HCLK) #1;
        HRESET = 1'b1;
        @(negedge HCLK);
        check("mid_pre_rst_req", 32'(ch_req_o), 32'h1);
        @(negedge HCLK);
        check("mrst_req",    32'(ch_req_o), 32'h0);
        check("mrst_wrn",    32'(ch_wrn_o), 32'h1);
        check("mrst_add",    32'(ch_add_o), 32'h0);
        check("mrst_data",   ch_data_o, 32'h0);
        check("mrst_ready",  32'(PREADY), 32'h0);
        check("mrst_slverr", 32'(PSLVERR), 32'h0);
        check("mrst_prdata", PRDATA, 32'h0);
        @(posedge HCLK) #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        HRESET = 1'b0;
        idle(10);
        apb(1'b0, 12'h00C, 32'h0, rd, er, waits);
        check("post_rst_err",   32'(er), 32'h0);
        check("post_rst_rdata", rd, 32'hDEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
